// File: rtl/cpu_axi_arbiter_pkg.sv
// Shared types and constants for the instruction/data AXI3 arbiter.
// FSM encodings, tied AXI field values and the request-size helper live here.
package cpu_axi_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [3:0] ID_INST    = 4'd0;
  localparam logic [3:0] ID_DATA    = 4'd1;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AWW  = 3'd3,
    S_B    = 3'd4,
    S_DONE = 3'd5
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  // Instruction fetches are always full words; data requests carry their own size.
  function automatic logic [2:0] grant_size(input logic is_data, input logic [1:0] size);
    return is_data ? {1'b0, size} : SIZE_WORD;
  endfunction

endpackage

// File: rtl/cpu_axi_arbiter_if.sv
// Bundle of the two sram-like requester ports and the single AXI3 master port.
// master: the arbiter's view; slave: the core + interconnect environment.
interface cpu_axi_arbiter_if;
  import cpu_axi_arbiter_pkg::*;

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [STRB_W-1:0] data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;

  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rready;

  logic [3:0]        awid;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [1:0]        awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;

  logic [3:0]        wid;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic              bvalid;
  logic              bready;

  modport master (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rdata, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rdata, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bvalid,
    input  bready
  );

endinterface

// File: rtl/cpu_axi_arbiter.sv
// One-outstanding, single-beat arbiter from the core's inst/data sram-like ports onto AXI3.
// Data has fixed priority; each granted request runs AR/R or AW+W/B, then pulses data_ok.
module cpu_axi_arbiter
  import cpu_axi_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  cpu_axi_arbiter_if.master bus,
  output state_t            o_state
);

  // Handshakes: a channel transfers on the rising edge where valid && ready are both 1;
  // a valid, once raised, holds its payload stable and stays up until that edge.
  state_t            r_state;
  state_t            w_state_nxt;
  owner_t            r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_size;
  logic [STRB_W-1:0] r_wstrb;
  logic [DATA_W-1:0] r_wdata;
  logic              r_aw_done;
  logic              r_w_done;
  logic [DATA_W-1:0] r_inst_rdata;
  logic [DATA_W-1:0] r_data_rdata;

  logic w_grant;
  logic w_grant_data;
  logic w_inst_addr_ok;
  logic w_data_addr_ok;
  logic w_inst_data_ok;
  logic w_data_data_ok;
  logic w_arvalid;
  logic w_rready;
  logic w_awvalid;
  logic w_wvalid;
  logic w_bready;
  logic w_aw_fire;
  logic w_w_fire;

  assign w_aw_fire = w_awvalid && bus.awready;
  assign w_w_fire  = w_wvalid  && bus.wready;

  always_comb begin
    w_state_nxt    = r_state;
    w_grant        = 1'b0;
    w_grant_data   = 1'b0;
    w_inst_addr_ok = 1'b0;
    w_data_addr_ok = 1'b0;
    w_inst_data_ok = 1'b0;
    w_data_data_ok = 1'b0;
    w_arvalid      = 1'b0;
    w_rready       = 1'b0;
    w_awvalid      = 1'b0;
    w_wvalid       = 1'b0;
    w_bready       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.data_req) begin
          w_grant        = 1'b1;
          w_grant_data   = 1'b1;
          w_data_addr_ok = 1'b1;
          w_state_nxt    = bus.data_wr ? S_AWW : S_AR;
        end else if (bus.inst_req) begin
          w_grant        = 1'b1;
          w_inst_addr_ok = 1'b1;
          w_state_nxt    = S_AR;
        end
      end
      S_AR: begin
        w_arvalid = 1'b1;
        if (bus.arready) w_state_nxt = S_R;
      end
      S_R: begin
        w_rready = 1'b1;
        if (bus.rvalid) w_state_nxt = S_DONE;
      end
      S_AWW: begin
        // AW and W complete independently; leave once both have transferred.
        w_awvalid = !r_aw_done;
        w_wvalid  = !r_w_done;
        if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) w_state_nxt = S_B;
      end
      S_B: begin
        w_bready = 1'b1;
        if (bus.bvalid) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (r_owner == OWN_DATA) w_data_data_ok = 1'b1;
        else                     w_inst_data_ok = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_INST;
      r_addr       <= '0;
      r_size       <= '0;
      r_wstrb      <= '0;
      r_wdata      <= '0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_owner   <= w_grant_data ? OWN_DATA : OWN_INST;
        r_addr    <= w_grant_data ? bus.data_addr : bus.inst_addr;
        r_size    <= grant_size(w_grant_data, bus.data_size);
        r_wstrb   <= w_grant_data ? bus.data_wstrb : '0;
        r_wdata   <= w_grant_data ? bus.data_wdata : '0;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_fire) r_aw_done <= 1'b1;
      if (w_w_fire)  r_w_done  <= 1'b1;
      if (r_state == S_R && bus.rvalid) begin
        if (r_owner == OWN_DATA) r_data_rdata <= bus.rdata;
        else                     r_inst_rdata <= bus.rdata;
      end
    end
  end

  assign o_state = r_state;

  assign bus.inst_addr_ok = w_inst_addr_ok;
  assign bus.inst_data_ok = w_inst_data_ok;
  assign bus.inst_rdata   = r_inst_rdata;
  assign bus.data_addr_ok = w_data_addr_ok;
  assign bus.data_data_ok = w_data_data_ok;
  assign bus.data_rdata   = r_data_rdata;

  assign bus.arid    = (r_owner == OWN_DATA) ? ID_DATA : ID_INST;
  assign bus.araddr  = r_addr;
  assign bus.arlen   = 4'd0;
  assign bus.arsize  = r_size;
  assign bus.arburst = BURST_INCR;
  assign bus.arlock  = 2'd0;
  assign bus.arcache = 4'd0;
  assign bus.arprot  = 3'd0;
  assign bus.arvalid = w_arvalid;
  assign bus.rready  = w_rready;

  assign bus.awid    = ID_DATA;
  assign bus.awaddr  = r_addr;
  assign bus.awlen   = 4'd0;
  assign bus.awsize  = r_size;
  assign bus.awburst = BURST_INCR;
  assign bus.awlock  = 2'd0;
  assign bus.awcache = 4'd0;
  assign bus.awprot  = 3'd0;
  assign bus.awvalid = w_awvalid;

  assign bus.wid    = ID_DATA;
  assign bus.wdata  = r_wdata;
  assign bus.wstrb  = r_wstrb;
  assign bus.wlast  = 1'b1;
  assign bus.wvalid = w_wvalid;
  assign bus.bready = w_bready;

endmodule
